// File: rtl/seq_detector_n_if.sv
// Bus bundle for seq_detector_n: sample strobe, serial bit, pattern load,
// mode and counter-clear controls in; match pulse and match count out.
//   master : drives controls/data, observes o and match_cnt
//   slave  : the detector
interface seq_detector_n_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
);
  logic             en;
  logic             i;
  logic             load;
  logic [N-1:0]     pattern;
  logic             overlap;
  logic             cnt_clr;
  logic             o;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, i, load, pattern, overlap, cnt_clr,
    input  o, match_cnt
  );

  modport slave (
    input  en, i, load, pattern, overlap, cnt_clr,
    output o, match_cnt
  );
endinterface

// File: rtl/seq_detector_n.sv
// Serial pattern detector with a runtime-loadable N-bit pattern, selectable
// overlap/non-overlap detection and a saturating match counter.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : seq_detector_n_if slave modport
//           (en, i, load, pattern, overlap, cnt_clr in; o, match_cnt out)
module seq_detector_n #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  seq_detector_n_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(N + 1);

  logic [N-1:0]      pat_q;
  logic [N-1:0]      hist;
  logic [FILL_W-1:0] fill;
  logic              o_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [N-1:0]      cand_c;
  logic              sample_c;
  logic              hit_c;
  logic [FILL_W-1:0] fill_inc_c;

  // Candidate window and hit; hit is masked until enough history is valid.
  always_comb begin
    cand_c     = {hist[N-2:0], bus.i};
    sample_c   = bus.en && !bus.load;
    hit_c      = sample_c && (fill >= FILL_W'(N - 1)) && (cand_c == pat_q);
    fill_inc_c = (fill == FILL_W'(N)) ? fill : fill + FILL_W'(1);
  end

  // Pattern capture, history shift and fill tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
      hist  <= '0;
      fill  <= '0;
      o_q   <= 1'b0;
    end else if (bus.load) begin
      pat_q <= bus.pattern;
      hist  <= '0;
      fill  <= '0;
      o_q   <= 1'b0;
    end else if (bus.en) begin
      hist <= cand_c;
      // Non-overlap only rewinds fill; stale hist bits are masked by fill.
      fill <= (hit_c && !bus.overlap) ? '0 : fill_inc_c;
      o_q  <= hit_c;
    end else begin
      o_q <= 1'b0;
    end
  end

  // Saturating match counter; clear wins over a coincident hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (bus.cnt_clr) begin
      cnt_q <= '0;
    end else if (hit_c && !(&cnt_q)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.o         = o_q;
  assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_detector_n.sv
// Testbench for seq_detector_n: two instances (N=4/CNT_W=3 and N=2/CNT_W=2)
// share control stimulus and are checked against a queue-based reference
// model every cycle, plus directed scenario checks.
module tb_seq_detector_n;

  logic clk;
  logic rst_n;

  seq_detector_n_if #(.N(4), .CNT_W(3)) if_a ();
  seq_detector_n_if #(.N(2), .CNT_W(2)) if_b ();

  seq_detector_n #(.N(4), .CNT_W(3)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  seq_detector_n #(.N(2), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: bits sampled since the last clear, pattern, count.
  bit         qa[$];
  bit         qb[$];
  logic [3:0] pa;
  logic [1:0] pb;
  int         cnt_a, cnt_b;
  bit         exp_oa, exp_ob;
  int         pulses_a, pulses_b;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // True when the last n sampled bits equal pat, oldest bit = pat[n-1].
  function automatic bit tail_hit(input bit q[$], input int n, input logic [3:0] pat);
    if (q.size() < n) return 1'b0;
    for (int k = 0; k < n; k++)
      if (q[q.size() - n + k] != pat[n - 1 - k]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    qa.delete(); qb.delete();
    pa = '0; pb = '0;
    cnt_a = 0; cnt_b = 0;
    exp_oa = 0; exp_ob = 0;
  endtask

  // One clock: drive at negedge, update model, check after posedge.
  task automatic cyc(input bit e, input bit bi, input bit ld, input logic [3:0] p,
                     input bit ov, input bit cl);
    @(negedge clk);
    if_a.en = e; if_a.i = bi; if_a.load = ld; if_a.pattern = p;
    if_a.overlap = ov; if_a.cnt_clr = cl;
    if_b.en = e; if_b.i = bi; if_b.load = ld; if_b.pattern = p[1:0];
    if_b.overlap = ov; if_b.cnt_clr = cl;
    exp_oa = 0; exp_ob = 0;
    if (ld) begin
      pa = p; pb = p[1:0];
      qa.delete(); qb.delete();
    end else if (e) begin
      qa.push_back(bi); if (qa.size() > 4) void'(qa.pop_front());
      qb.push_back(bi); if (qb.size() > 2) void'(qb.pop_front());
      exp_oa = tail_hit(qa, 4, pa);
      exp_ob = tail_hit(qb, 2, {2'b00, pb});
      if (exp_oa && !ov) qa.delete();
      if (exp_ob && !ov) qb.delete();
    end
    if (cl) cnt_a = 0; else if (exp_oa && cnt_a < 7) cnt_a++;
    if (cl) cnt_b = 0; else if (exp_ob && cnt_b < 3) cnt_b++;
    @(posedge clk);
    #1;
    check("o_a", int'(if_a.o), int'(exp_oa));
    check("cnt_a", int'(if_a.match_cnt), cnt_a);
    check("o_b", int'(if_b.o), int'(exp_ob));
    check("cnt_b", int'(if_b.match_cnt), cnt_b);
    if (if_a.o) pulses_a++;
    if (if_b.o) pulses_b++;
  endtask

  task automatic send(input bit bi, input bit ov);
    cyc(1, bi, 0, 4'b0000, ov, 0);
  endtask

  task automatic prep(input logic [3:0] p, input bit ov);
    cyc(0, 0, 1, p, ov, 1);
    pulses_a = 0; pulses_b = 0;
  endtask

  initial begin
    bit s7[7];
    s7 = '{1, 0, 1, 1, 0, 1, 1};

    rst_n = 0;
    if_a.en = 0; if_a.i = 0; if_a.load = 0; if_a.pattern = '0; if_a.overlap = 0; if_a.cnt_clr = 0;
    if_b.en = 0; if_b.i = 0; if_b.load = 0; if_b.pattern = '0; if_b.overlap = 0; if_b.cnt_clr = 0;
    model_reset();
    #1;
    check("rst_o_a", int'(if_a.o), 0);
    check("rst_cnt_a", int'(if_a.match_cnt), 0);
    #12;
    @(negedge clk) rst_n = 1;

    // Overlap: pulses after bits 4 and 7.
    prep(4'b1011, 1);
    foreach (s7[k]) send(s7[k], 1);
    check("ovl_pulses", pulses_a, 2);
    check("ovl_cnt", int'(if_a.match_cnt), 2);

    // Non-overlap: pulse after bit 4 only.
    prep(4'b1011, 0);
    foreach (s7[k]) send(s7[k], 0);
    check("novl_pulses", pulses_a, 1);
    check("novl_cnt", int'(if_a.match_cnt), 1);

    // en gap of 3 cycles between bits 2 and 3.
    prep(4'b1011, 1);
    foreach (s7[k]) begin
      if (k == 2) repeat (3) cyc(0, 1, 0, 4'b0000, 1, 0);
      send(s7[k], 1);
    end
    check("gap_pulses", pulses_a, 2);

    // Load mid-stream clears history; load with en=1 discards the bit.
    prep(4'b1011, 1);
    send(1, 1); send(0, 1); send(1, 1);
    cyc(1, 1, 1, 4'b1011, 1, 0);
    check("load_disc_o", int'(if_a.o), 0);
    send(0, 1); send(1, 1); send(1, 1);
    check("load_nomatch", pulses_a, 0);
    send(1, 1); send(0, 1); send(1, 1); send(1, 1);
    check("load_single", pulses_a, 1);

    // N=2 pattern 00: five back-to-back hits, counter saturates at 3.
    prep(4'b0000, 1);
    repeat (6) send(0, 1);
    check("sat_pulses_b", pulses_b, 5);
    check("sat_cnt_b", int'(if_b.match_cnt), 3);

    // cnt_clr coincident with the 5th hit.
    prep(4'b0000, 1);
    repeat (5) send(0, 1);
    cyc(1, 0, 0, 4'b0000, 1, 1);
    check("clr_hit_o_b", int'(if_b.o), 1);
    check("clr_hit_cnt_b", int'(if_b.match_cnt), 0);

    // Async reset while o=1, then all-zero pattern after release.
    prep(4'b1011, 1);
    send(1, 1); send(0, 1); send(1, 1); send(1, 1);
    check("pre_rst_o_a", int'(if_a.o), 1);
    #2 rst_n = 0;
    #1;
    check("async_o_a", int'(if_a.o), 0);
    check("async_cnt_a", int'(if_a.match_cnt), 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    pulses_a = 0;
    repeat (4) send(0, 1);
    check("post_rst_zero", pulses_a, 1);

    // Randomized traffic against the model.
    begin
      logic [3:0] rp;
      bit         rov;
      rp = 4'(($urandom));
      rov = 1;
      for (int c = 0; c < 3000; c++) begin
        bit re, ri, rl, rc;
        re = ($urandom_range(0, 3) != 0);
        ri = 1'($urandom);
        rl = ($urandom_range(0, 39) == 0);
        rc = ($urandom_range(0, 59) == 0);
        if ($urandom_range(0, 9) == 0) rov = ~rov;
        if (rl) rp = 4'($urandom);
        cyc(re, ri, rl, rp, rov, rc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detector_n.md
# seq_detector_n

Parametrised serial pattern detector. It compares an incoming 1-bit stream against a runtime-loadable N-bit pattern and produces a one-cycle match pulse. A saturating match counter is included. Overlap or non-overlap detection is selectable at run time. The block is the generalised successor of the fixed 3-state sequence-detector FSM and sits directly on a serial input bit stream sampled under a strobe.

## Interface
- N, default 4: pattern length in bits; legal range 2..16.
- CNT_W, default 8: width of the match counter; legal range 1..16.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  sample strobe; `i` is consumed only on cycles with en=1.
- i  input  1  serial data bit.
- load  input  1  captures `pattern` and clears history; has priority over en.
- pattern  input  N  pattern to detect; `pattern[N-1]` is the first bit received.
- overlap  input  1  1 = overlapping matches allowed, 0 = history cleared after each match; sampled every en cycle.
- cnt_clr  input  1  synchronous clear of match_cnt.
- o  output  1  registered match pulse, one clk wide.
- match_cnt  output  CNT_W  saturating count of matches since reset or cnt_clr.

## Operation
- Internal state:
  - pat_q[N-1:0]: captured pattern.
  - hist[N-1:0]: shift history.
  - fill[$clog2(N+1)-1:0]: number of valid history bits, range 0..N.
- Fill phases:
  - EMPTY: fill=0.
  - FILLING: 0<fill<N-1.
  - ARMED: fill>=N-1, meaning the next sample can complete a match.
- Reset (async, rst_n=0): pat_q=0, hist=0, fill=0, o=0, match_cnt=0, all immediately. The reset value of pat_q means an all-zero pattern is detected until the first load.
- Priority per cycle: load > en.
- Load cycle: pat_q<=pattern, hist<=0, fill<=0, o<=0. `i` is ignored even if en=1.
- Idle cycle (en=0, load=0): hist and fill hold; o<=0.
- Sample cycle (en=1, load=0):
  - cand = {hist[N-2:0], i}; hit = (fill>=N-1) && (cand==pat_q).
  - hist<=cand.
  - If hit && overlap=0: fill<=0.
  - Otherwise: fill<=min(fill+1, N).
  - o<=hit.
- Non-overlap clears only fill. hist contents are don't-care while fill<N-1, because hit is masked by fill.
- match_cnt, evaluated on each edge:
  - If cnt_clr=1: match_cnt<=0. The clear wins over a simultaneous hit; that match is not counted, but o still pulses.
  - Else if hit and match_cnt != all-ones: increment.
  - Else if hit and match_cnt is all-ones: hold (saturate, no wrap).
- Changing `overlap` mid-stream takes effect on the next sample. It does not retroactively alter fill.
- Changing `pattern` without load has no effect.

## Timing
- Latency: o rises on the clk edge that samples the final pattern bit. It is visible during the following cycle and is high for exactly one cycle per hit.
- match_cnt updates on the same edge as o.
- Throughput: one bit per cycle with en held high. Back-to-back hits produce o high on consecutive cycles (possible in overlap mode, e.g. pattern all-ones or all-zeros).
- After load or a non-overlap match, at least N sample cycles are required before the next hit.
- fill saturates at N and never wraps.
- Reset mid-stream: o and match_cnt drop asynchronously when rst_n falls. The first sample after rst_n rises starts from EMPTY.
- A load in the same cycle as the final pattern bit discards that bit: no hit, o=0.

## Test plan
- N=4, load 1011, overlap=1, en=1, stream 1,0,1,1,0,1,1 -> o pulses after bits 4 and 7; match_cnt=2.
- Same stream with overlap=0 -> o pulses after bit 4 only; match_cnt=1.
- N=4, pattern 1011, same stream with en=0 for 3 cycles inserted between bits 2 and 3 -> identical o pulses, only on sample cycles; history held across the gap.
- Stream 1,0,1 then load (pattern 1011), then 0,1,1 -> no match; 4 further bits 1,0,1,1 -> single pulse.
- CNT_W=2, N=2, pattern 00, overlap=1, six consecutive 0s -> o high for 5 consecutive cycles; match_cnt=3 (saturated). cnt_clr coincident with the 5th hit -> match_cnt=0 and o=1 on that edge.
- rst_n pulsed low mid-stream while o=1 -> o=0 and match_cnt=0 immediately; pat_q=0. After release, N zeros -> one match.
